// File: rtl/cache_bus_pkg.sv
// cache_bus_pkg: shared encodings for the I-cache / D-cache bus arbiter.
// Holds the FSM state type, owner ids and sram-like size codes.
package cache_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADDR = 2'b01,
        DATA = 2'b10
    } state_t;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

endpackage

// File: rtl/arb_pick.sv
// arb_pick: combinational two-way picker between I-side and D-side requests.
// Define ARB_RR_EN for round-robin on collisions; otherwise D-side has fixed priority.
module arb_pick
    import cache_bus_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  logic last_owner,
    output logic grant_valid,
    output logic grant_id
);

`ifndef ARB_RR_EN
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
`endif

    always_comb begin
        grant_valid = i_req | d_req;
        grant_id    = OWN_I;
        if (i_req && d_req) begin
`ifdef ARB_RR_EN
            grant_id = (last_owner == OWN_I) ? OWN_D : OWN_I;
`else
            grant_id = OWN_D;
`endif
        end else if (d_req) begin
            grant_id = OWN_D;
        end
    end

endmodule

// File: rtl/cache_bus_arbiter.sv
// cache_bus_arbiter: serialises I-cache and D-cache traffic onto one sram-like AXI bridge port.
// Define ARB_RR_EN for round-robin arbitration; the default build uses fixed D-side priority.
module cache_bus_arbiter
    import cache_bus_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic              i_wr,
    input  logic [1:0]        i_size,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_addr_ok,
    output logic              i_data_ok,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_addr_ok,
    output logic              d_data_ok,
    output logic              m_req,
    output logic              m_wr,
    output logic [1:0]        m_size,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_addr_ok,
    input  logic              m_data_ok
);

    state_t state, state_nxt;
    logic   last_owner;   // also names the owner of the transaction in flight
    logic   grant_valid, grant_id, grant;
    logic   addr_ok, data_ok;

    arb_pick u_pick (
        .i_req       (i_req),
        .d_req       (d_req),
        .last_owner  (last_owner),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_nxt = state;
        grant     = 1'b0;
        addr_ok   = 1'b0;
        data_ok   = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    grant     = 1'b1;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                if (m_addr_ok) begin
                    addr_ok = 1'b1;
                    if (m_data_ok) begin
                        data_ok   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (m_data_ok) begin
                    data_ok   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_owner <= OWN_I;
            m_wr       <= 1'b0;
            m_size     <= SZ_B;
            m_addr     <= '0;
            m_wdata    <= '0;
        end else begin
            state <= state_nxt;
            if (grant) begin
                last_owner <= grant_id;
                if (grant_id == OWN_D) begin
                    m_wr    <= d_wr;
                    m_size  <= d_size;
                    m_addr  <= d_addr;
                    m_wdata <= d_wdata;
                end else begin
                    m_wr    <= i_wr;
                    m_size  <= i_size;
                    m_addr  <= i_addr;
                    m_wdata <= i_wdata;
                end
            end
        end
    end

    assign m_req     = (state == ADDR);
    assign i_addr_ok = addr_ok && (last_owner == OWN_I);
    assign d_addr_ok = addr_ok && (last_owner == OWN_D);
    assign i_data_ok = data_ok && (last_owner == OWN_I);
    assign d_data_ok = data_ok && (last_owner == OWN_D);
    assign i_rdata   = m_rdata;
    assign d_rdata   = m_rdata;

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// tb_cache_bus_arbiter: directed and randomized checks of cache_bus_arbiter against a
// transaction-level model of the arbitration policy (honours ARB_RR_EN like the DUT).
`timescale 1ns/1ps
module tb_cache_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 0, i_wr = 0, d_req = 0, d_wr = 0;
    logic [1:0]  i_size = 0, d_size = 0;
    logic [31:0] i_addr = 0, i_wdata = 0, d_addr = 0, d_wdata = 0;
    logic [31:0] i_rdata, d_rdata;
    logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
    logic        m_req, m_wr;
    logic [1:0]  m_size;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] m_rdata = 0;
    logic        m_addr_ok = 0, m_data_ok = 0;
    logic [3:0]  oks;

    int tests_run = 0;
    int tests_failed = 0;
    bit model_last_d = 0;   // model: 1 when the most recent grant went to D

    typedef struct {
        int          req_lat;
        bit          timeout;
        logic        aok_i, aok_d, dok_i, dok_d;
        logic [31:0] rdata_i, rdata_d;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr, wdata;
        bit          held;
        int          stray;
        bit          idle_after;
    } obs_t;

    typedef struct {
        bit          own_d;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr, wdata;
    } exp_t;

    cache_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok)
    );

    assign oks = {i_addr_ok, d_addr_ok, i_data_ok, d_data_ok};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Policy model: who wins given the current requests and the previous winner.
    function automatic exp_t predict();
        exp_t e;
        if (i_req && d_req) begin
`ifdef ARB_RR_EN
            e.own_d = !model_last_d;
`else
            e.own_d = 1'b1;
`endif
        end else begin
            e.own_d = d_req;
        end
        model_last_d = e.own_d;
        e.wr    = e.own_d ? d_wr    : i_wr;
        e.size  = e.own_d ? d_size  : i_size;
        e.addr  = e.own_d ? d_addr  : i_addr;
        e.wdata = e.own_d ? d_wdata : i_wdata;
        return e;
    endfunction

    // Bridge + requester behaviour for one transaction; called at a negedge in IDLE with
    // requests already driven. Records what the DUT showed; the tests judge it.
    task automatic run_txn(input int aw, input int dw, input logic [31:0] rd,
                           input logic [31:0] new_addr, input bit spur, output obs_t o);
        o = '{default: 0};
        do begin
            @(posedge clk); @(negedge clk);
            o.req_lat++;
        end while (m_req !== 1'b1 && o.req_lat < 8);
        if (m_req !== 1'b1) begin
            o.timeout = 1'b1;
            return;
        end
        o.wr = m_wr; o.size = m_size; o.addr = m_addr; o.wdata = m_wdata; o.held = 1'b1;
        for (int k = 0; k < aw; k++) begin
            if (oks !== 4'b0) o.stray++;
            @(posedge clk); @(negedge clk);
            if ({m_wr, m_size, m_addr, m_wdata} !== {o.wr, o.size, o.addr, o.wdata}) o.held = 1'b0;
        end
        m_addr_ok = 1'b1;
        m_rdata   = $urandom;
        if (dw == 0) begin
            m_data_ok = 1'b1;
            m_rdata   = rd;
        end
        #1;
        o.aok_i = i_addr_ok; o.aok_d = d_addr_ok;
        if (dw == 0) begin
            o.dok_i = i_data_ok; o.dok_d = d_data_ok; o.rdata_i = i_rdata; o.rdata_d = d_rdata;
        end else if ((i_data_ok | d_data_ok) !== 1'b0) begin
            o.stray++;
        end
        @(posedge clk); #1;
        m_addr_ok = 1'b0;
        m_data_ok = 1'b0;
        // the accepted requester withdraws and moves its inputs on
        if (o.aok_i === 1'b1) begin i_req = 1'b0; i_addr = new_addr; i_wdata = ~i_wdata; end
        if (o.aok_d === 1'b1) begin d_req = 1'b0; d_addr = new_addr; d_wdata = ~d_wdata; end
        if (dw > 0) begin
            for (int k = 1; k < dw; k++) begin
                @(negedge clk);
                if (m_req !== 1'b0 || oks !== 4'b0) o.stray++;
                if ({m_wr, m_size, m_addr, m_wdata} !== {o.wr, o.size, o.addr, o.wdata}) o.held = 1'b0;
                m_addr_ok = spur;   // an addr_ok during DATA must be ignored
                #1;
                if (oks !== 4'b0) o.stray++;
                @(posedge clk); #1;
                m_addr_ok = 1'b0;
            end
            @(negedge clk);
            if ({m_wr, m_size, m_addr, m_wdata} !== {o.wr, o.size, o.addr, o.wdata}) o.held = 1'b0;
            m_data_ok = 1'b1;
            m_rdata   = rd;
            #1;
            o.dok_i = i_data_ok; o.dok_d = d_data_ok; o.rdata_i = i_rdata; o.rdata_d = d_rdata;
            if ((i_addr_ok | d_addr_ok) !== 1'b0) o.stray++;
            @(posedge clk); #1;
            m_data_ok = 1'b0;
            m_rdata   = $urandom;
        end
        @(negedge clk);
        o.idle_after = (m_req === 1'b0) && (oks === 4'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_rdata = 32'hA5A5_0F0F;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({m_req, m_wr, m_size, m_addr, m_wdata} !== 68'h0) begin
            tests_failed++;
            $display("FAIL reset_cmd: got req=%b wr=%b size=%b addr=%h wdata=%h, expected all 0",
                     m_req, m_wr, m_size, m_addr, m_wdata);
        end
        tests_run++;
        if (oks !== 4'b0) begin
            tests_failed++;
            $display("FAIL reset_oks: got %b, expected 0000", oks);
        end
        tests_run++;
        if (i_rdata !== 32'hA5A5_0F0F || d_rdata !== 32'hA5A5_0F0F) begin
            tests_failed++;
            $display("FAIL rdata_copy: got i=%h d=%h, expected a5a50f0f", i_rdata, d_rdata);
        end
        rst = 1'b0;
        model_last_d = 1'b0;
    endtask

    task automatic test_single_d_read();
        obs_t o;
        exp_t e;
        d_req = 1'b1; d_wr = 1'b0; d_size = 2'b10; d_addr = 32'h1000_0004; d_wdata = 32'h0;
        e = predict();
        run_txn(0, 2, 32'hDEAD_BEEF, 32'h1000_0008, 1'b0, o);
        tests_run++;
        if (o.timeout || o.req_lat != 1) begin
            tests_failed++;
            $display("FAIL d_read_latency: got m_req after %0d cycles, expected 1", o.req_lat);
        end
        tests_run++;
        if ({o.aok_i, o.aok_d, o.dok_i, o.dok_d} !== 4'b0101 || o.stray != 0) begin
            tests_failed++;
            $display("FAIL d_read_oks: got %b stray=%0d, expected 0101 stray=0",
                     {o.aok_i, o.aok_d, o.dok_i, o.dok_d}, o.stray);
        end
        tests_run++;
        if (o.rdata_d !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL d_read_rdata: got %h, expected deadbeef", o.rdata_d);
        end
        tests_run++;
        if ({o.wr, o.size, o.addr} !== {e.wr, e.size, e.addr} || !o.idle_after) begin
            tests_failed++;
            $display("FAIL d_read_cmd: got wr=%b size=%b addr=%h idle=%b, expected %b %b %h 1",
                     o.wr, o.size, o.addr, o.idle_after, e.wr, e.size, e.addr);
        end
    endtask

    task automatic test_simultaneous();
        obs_t o;
        exp_t e;
        bit   first_d;
`ifdef ARB_RR_EN
        first_d = 1'b0;   // last owner was D, so I wins
`else
        first_d = 1'b1;
`endif
        i_req = 1'b1; i_wr = 1'b0; i_size = 2'b10; i_addr = 32'h0000_1100; i_wdata = 32'h1;
        d_req = 1'b1; d_wr = 1'b0; d_size = 2'b10; d_addr = 32'h2000_0200; d_wdata = 32'h2;
        for (int n = 0; n < 5; n++) begin
            if (n >= 2) begin
                i_req = 1'b1;
                d_req = 1'b1;
            end
            e = predict();
            run_txn(n % 2, 1, 32'h5000_0000 + n, 32'h3000_0000 + n, 1'b0, o);
            if (n == 0) begin
                tests_run++;
                if (o.aok_d !== first_d) begin
                    tests_failed++;
                    $display("FAIL collision_first: got d_addr_ok=%b, expected %b", o.aok_d, first_d);
                end
            end
            tests_run++;
            if ({o.aok_i, o.aok_d, o.dok_i, o.dok_d} !== (e.own_d ? 4'b0101 : 4'b1010) ||
                o.addr !== e.addr || o.req_lat != 1 || o.stray != 0) begin
                tests_failed++;
                $display("FAIL collision_%0d: got oks=%b addr=%h lat=%0d stray=%0d, expected own_d=%b addr=%h lat=1",
                         n, {o.aok_i, o.aok_d, o.dok_i, o.dok_d}, o.addr, o.req_lat, o.stray,
                         e.own_d, e.addr);
            end
        end
        i_req = 1'b0;
        d_req = 1'b0;
        repeat (2) @(negedge clk);
        model_last_d = 1'b1;   // the final collision's leftover request is withdrawn ungranted
        if (e.own_d == 1'b0) model_last_d = 1'b0;
    endtask

    task automatic test_cmd_stability();
        obs_t o;
        exp_t e;
        d_req = 1'b1; d_wr = 1'b1; d_size = 2'b00; d_addr = 32'h0000_0020; d_wdata = 32'h1234_5678;
        e = predict();
        run_txn(1, 3, 32'h0, 32'h0000_0040, 1'b0, o);
        tests_run++;
        if ({o.wr, o.size, o.addr, o.wdata} !== {1'b1, 2'b00, 32'h0000_0020, 32'h1234_5678}) begin
            tests_failed++;
            $display("FAIL stab_cmd: got wr=%b size=%b addr=%h wdata=%h, expected 1 00 00000020 12345678",
                     o.wr, o.size, o.addr, o.wdata);
        end
        tests_run++;
        if (!o.held || {o.aok_i, o.aok_d, o.dok_i, o.dok_d} !== 4'b0101) begin
            tests_failed++;
            $display("FAIL stab_held: got held=%b oks=%b, expected held=1 oks=0101",
                     o.held, {o.aok_i, o.aok_d, o.dok_i, o.dok_d});
        end
    endtask

    task automatic test_same_cycle();
        obs_t o;
        exp_t e;
        i_req = 1'b1; i_wr = 1'b0; i_size = 2'b10; i_addr = 32'h0000_0400; i_wdata = 32'h0;
        e = predict();
        run_txn(0, 0, 32'hCAFE_F00D, 32'h0000_0404, 1'b0, o);
        tests_run++;
        if ({o.aok_i, o.aok_d, o.dok_i, o.dok_d} !== 4'b1010 || o.rdata_i !== 32'hCAFE_F00D) begin
            tests_failed++;
            $display("FAIL same_cycle: got oks=%b rdata=%h, expected 1010 cafef00d",
                     {o.aok_i, o.aok_d, o.dok_i, o.dok_d}, o.rdata_i);
        end
        tests_run++;
        if (!o.idle_after || o.addr !== e.addr) begin
            tests_failed++;
            $display("FAIL same_cycle_idle: got idle=%b addr=%h, expected 1 %h", o.idle_after, o.addr, e.addr);
        end
    endtask

    task automatic test_spurious();
        @(negedge clk);
        m_data_ok = 1'b1;
        m_addr_ok = 1'b1;
        #1;
        tests_run++;
        if (oks !== 4'b0) begin
            tests_failed++;
            $display("FAIL spurious_oks: got %b, expected 0000", oks);
        end
        @(posedge clk); #1;
        m_data_ok = 1'b0;
        m_addr_ok = 1'b0;
        @(negedge clk);
        tests_run++;
        if (m_req !== 1'b0 || oks !== 4'b0) begin
            tests_failed++;
            $display("FAIL spurious_state: got m_req=%b oks=%b, expected 0 0000", m_req, oks);
        end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        exp_t e;
        i_req = 1'b1; i_wr = 1'b0; i_size = 2'b10; i_addr = 32'h0000_0800;
        @(posedge clk); @(negedge clk);
        m_addr_ok = 1'b1;
        @(posedge clk); #1;
        m_addr_ok = 1'b0;
        i_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        m_data_ok = 1'b1;   // late completion from the abandoned transaction
        @(negedge clk);
        tests_run++;
        if (m_req !== 1'b0 || oks !== 4'b0 || m_addr !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_mid: got m_req=%b oks=%b m_addr=%h, expected 0 0000 0", m_req, oks, m_addr);
        end
        rst = 1'b0;
        model_last_d = 1'b0;
        @(posedge clk); #1;
        m_data_ok = 1'b0;
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h0000_0C00; i_size = 2'b01;
        e = predict();
        run_txn(1, 1, 32'h7777_0001, 32'h0, 1'b0, o);
        tests_run++;
        if ({o.aok_i, o.aok_d, o.dok_i, o.dok_d} !== 4'b1010 || o.rdata_i !== 32'h7777_0001 ||
            o.addr !== e.addr || o.req_lat != 1) begin
            tests_failed++;
            $display("FAIL after_reset: got oks=%b rdata=%h addr=%h lat=%0d, expected 1010 77770001 %h 1",
                     {o.aok_i, o.aok_d, o.dok_i, o.dok_d}, o.rdata_i, o.addr, o.req_lat, e.addr);
        end
    endtask

    task automatic test_random();
        obs_t        o;
        exp_t        e;
        logic [31:0] rd;
        int          aw, dw;
        bit          sp;
        for (int n = 0; n < 40; n++) begin
            if (!i_req && $urandom_range(0, 1) == 1) begin
                i_req = 1'b1; i_wr = 1'($urandom_range(0, 1)); i_size = 2'($urandom_range(0, 2));
                i_addr = $urandom; i_wdata = $urandom;
            end
            if (!d_req && ($urandom_range(0, 1) == 1 || !i_req)) begin
                d_req = 1'b1; d_wr = 1'($urandom_range(0, 1)); d_size = 2'($urandom_range(0, 2));
                d_addr = $urandom; d_wdata = $urandom;
            end
            e  = predict();
            aw = $urandom_range(0, 3);
            dw = $urandom_range(0, 3);
            rd = $urandom;
            sp = 1'($urandom_range(0, 1));
            run_txn(aw, dw, rd, $urandom, sp, o);
            tests_run++;
            if (o.timeout || o.req_lat != 1 || o.stray != 0 || !o.idle_after || !o.held) begin
                tests_failed++;
                $display("FAIL rand_%0d_timing: got lat=%0d timeout=%b stray=%0d idle=%b held=%b, expected 1 0 0 1 1",
                         n, o.req_lat, o.timeout, o.stray, o.idle_after, o.held);
            end
            tests_run++;
            if ({o.aok_i, o.aok_d, o.dok_i, o.dok_d} !== (e.own_d ? 4'b0101 : 4'b1010) ||
                (e.own_d ? o.rdata_d : o.rdata_i) !== rd) begin
                tests_failed++;
                $display("FAIL rand_%0d_resp: got oks=%b rdata=%h, expected own_d=%b rdata=%h",
                         n, {o.aok_i, o.aok_d, o.dok_i, o.dok_d}, e.own_d ? o.rdata_d : o.rdata_i,
                         e.own_d, rd);
            end
            tests_run++;
            if ({o.wr, o.size, o.addr, o.wdata} !== {e.wr, e.size, e.addr, e.wdata}) begin
                tests_failed++;
                $display("FAIL rand_%0d_cmd: got %b %b %h %h, expected %b %b %h %h", n,
                         o.wr, o.size, o.addr, o.wdata, e.wr, e.size, e.addr, e.wdata);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_d_read();
        test_simultaneous();
        test_cmd_stability();
        test_same_cycle();
        test_spurious();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
